// File: rtl/vga_apb_pkg.sv
// Shared definitions for the VGA pixel APB master: register map, write steps and
// the APB transfer state encoding.
package vga_apb_pkg;

  localparam logic [3:0] ADDR_X     = 4'h0;
  localparam logic [3:0] ADDR_Y     = 4'h4;
  localparam logic [3:0] ADDR_COLOR = 4'h8;
  localparam logic [3:0] ADDR_WE    = 4'hC;

  typedef enum logic [1:0] {STEP_X, STEP_Y, STEP_COLOR, STEP_WE} step_e;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} apb_state_e;

  function automatic logic [3:0] step_offset(step_e s);
    case (s)
      STEP_X:     return ADDR_X;
      STEP_Y:     return ADDR_Y;
      STEP_COLOR: return ADDR_COLOR;
      default:    return ADDR_WE;
    endcase
  endfunction

endpackage

// File: rtl/apb_single_write.sv
// One APB write transfer (SETUP then ACCESS) with an optional pready timeout.
// A new transfer may be chained directly from the last ACCESS cycle of the previous one.
module apb_single_write
  import vga_apb_pkg::*;
#(
  parameter int AW             = 12,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          busy_o,
  output logic          xfer_end_o,
  output logic          xfer_err_o,
  output logic [AW-1:0] paddr_o,
  output logic [DW-1:0] pwdata_o,
  output logic          pwrite_o,
  output logic          psel_o,
  output logic          penable_o,
  input  logic          pready_i,
  input  logic          pslverr_i
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  apb_state_e    state_q, state_d;
  logic          psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_hit, xfer_end, xfer_err;

  // cnt_q counts wait cycles already spent; this cycle being the last allowed one aborts.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    cnt_d     = cnt_q;
    xfer_end  = 1'b0;
    xfer_err  = 1'b0;
    case (state_q)
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          xfer_end = 1'b1;
          xfer_err = pslverr_i;
        end else if (timeout_hit) begin
          xfer_end = 1'b1;
          xfer_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (xfer_end) begin
          state_d   = ST_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_i && (state_q == ST_IDLE || xfer_end)) begin
      state_d   = ST_SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = 1'b1;
      paddr_d   = addr_i;
      pwdata_d  = wdata_i;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign xfer_end_o = xfer_end;
  assign xfer_err_o = xfer_err;
  assign paddr_o    = paddr_q;
  assign pwdata_o   = pwdata_q;
  assign pwrite_o   = pwrite_q;
  assign psel_o     = psel_q;
  assign penable_o  = penable_q;

endmodule

// File: rtl/vga_apb_pixel_master.sv
// Pixel-write sequencer: turns one (x, y, color) request into APB writes of X, Y,
// COLOR and WE, skipping register writes that would not change the peripheral.
module vga_apb_pixel_master
  import vga_apb_pkg::*;
#(
  parameter int                        APB_ADDR_WIDTH = 12,
  parameter int                        APB_DATA_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter bit                        SKIP_REDUNDANT = 1'b1,
  parameter int                        TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [10:0]               req_x_i,
  input  logic [10:0]               req_y_i,
  input  logic                      req_color_i,
  output logic                      done_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
  output logic                      apb_pwrite_o,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
  input  logic                      apb_pready_i,
  input  logic                      apb_pslverr_i
);

  logic                      busy, xfer_end, xfer_err, start, accept, step_ok;
  logic [APB_ADDR_WIDTH-1:0] start_addr;
  logic [APB_DATA_WIDTH-1:0] start_data;
  logic [10:0]               x_q, x_d, y_q, y_d, sh_x_q, sh_x_d, sh_y_q, sh_y_d, cur_x, cur_y;
  logic                      color_q, color_d, sh_c_q, sh_c_d, cur_c;
  logic [2:0]                sh_valid_q, sh_valid_d, skip;
  logic                      done_q, done_d, err_q, err_d;
  step_e                     step_q, step_d, nxt;
  logic [1:0]                from_idx;
  logic                      prdata_unused;

  assign prdata_unused = ^apb_prdata_i;

  // The done cycle is still part of the sequence, so no request is taken there.
  assign req_ready_o = !busy && !done_q;

  always_comb begin
    accept   = req_valid_i && req_ready_o;
    step_ok  = xfer_end && !xfer_err;
    cur_x    = req_ready_o ? req_x_i : x_q;
    cur_y    = req_ready_o ? req_y_i : y_q;
    cur_c    = req_ready_o ? req_color_i : color_q;
    skip[0]  = SKIP_REDUNDANT && sh_valid_q[0] && (cur_x == sh_x_q);
    skip[1]  = SKIP_REDUNDANT && sh_valid_q[1] && (cur_y == sh_y_q);
    skip[2]  = SKIP_REDUNDANT && sh_valid_q[2] && (cur_c == sh_c_q);
    from_idx = req_ready_o ? 2'd0 : step_q + 2'd1;
    if (from_idx == 2'd0 && !skip[0])       nxt = STEP_X;
    else if (from_idx <= 2'd1 && !skip[1])  nxt = STEP_Y;
    else if (from_idx <= 2'd2 && !skip[2])  nxt = STEP_COLOR;
    else                                    nxt = STEP_WE;
    start      = accept || (step_ok && step_q != STEP_WE);
    start_addr = BASE_ADDR + APB_ADDR_WIDTH'(step_offset(nxt));
    case (nxt)
      STEP_X:     start_data = APB_DATA_WIDTH'(cur_x);
      STEP_Y:     start_data = APB_DATA_WIDTH'(cur_y);
      STEP_COLOR: start_data = APB_DATA_WIDTH'(cur_c);
      default:    start_data = APB_DATA_WIDTH'(1);
    endcase

    x_d        = accept ? req_x_i : x_q;
    y_d        = accept ? req_y_i : y_q;
    color_d    = accept ? req_color_i : color_q;
    step_d     = start ? nxt : step_q;
    sh_x_d     = sh_x_q;
    sh_y_d     = sh_y_q;
    sh_c_d     = sh_c_q;
    sh_valid_d = sh_valid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (step_ok) begin
      case (step_q)
        STEP_X:     begin sh_x_d = x_q;     sh_valid_d[0] = 1'b1; end
        STEP_Y:     begin sh_y_d = y_q;     sh_valid_d[1] = 1'b1; end
        STEP_COLOR: begin sh_c_d = color_q; sh_valid_d[2] = 1'b1; end
        default:    done_d = 1'b1;
      endcase
    end
    // An aborted sequence leaves the peripheral state unknown, so forget all shadows.
    if (xfer_end && xfer_err) begin
      sh_valid_d = '0;
      done_d     = 1'b1;
      err_d      = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q        <= '0;
      y_q        <= '0;
      color_q    <= 1'b0;
      step_q     <= STEP_X;
      sh_x_q     <= '0;
      sh_y_q     <= '0;
      sh_c_q     <= 1'b0;
      sh_valid_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      color_q    <= color_d;
      step_q     <= step_d;
      sh_x_q     <= sh_x_d;
      sh_y_q     <= sh_y_d;
      sh_c_q     <= sh_c_d;
      sh_valid_q <= sh_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign done_o = done_q;
  assign err_o  = err_q;

  apb_single_write #(
    .AW             (APB_ADDR_WIDTH),
    .DW             (APB_DATA_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_write (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start),
    .addr_i     (start_addr),
    .wdata_i    (start_data),
    .busy_o     (busy),
    .xfer_end_o (xfer_end),
    .xfer_err_o (xfer_err),
    .paddr_o    (apb_paddr_o),
    .pwdata_o   (apb_pwdata_o),
    .pwrite_o   (apb_pwrite_o),
    .psel_o     (apb_psel_o),
    .penable_o  (apb_penable_o),
    .pready_i   (apb_pready_i),
    .pslverr_i  (apb_pslverr_i)
  );

endmodule

// File: tb/tb_vga_apb_pixel_master.sv
// Scoreboard bench: expected APB writes and done events are queued by the driver and
// popped by the responder/monitor processes as the design presents them.
module tb_vga_apb_pixel_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_c = 1'b0;
  logic [10:0] req_x = '0, req_y = '0;
  logic        done, err, pwrite, psel, penable;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        pready = 1'b0, pslverr = 1'b0;

  typedef struct { logic [11:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int lat; logic err; } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];
  wr_t   we;
  done_t de;
  int    wait_cfg[4];
  logic  err_cfg[4];
  logic  hang = 1'b0;
  int    checks = 0, errors = 0, cyc = 0, acc_cyc = 0, done_seen = 0, wcnt = 0;
  logic [11:0] setup_addr = '0;
  logic [31:0] setup_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_apb_pixel_master dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_x_i       (req_x),
    .req_y_i       (req_y),
    .req_color_i   (req_c),
    .done_o        (done),
    .err_o         (err),
    .apb_paddr_o   (paddr),
    .apb_pwdata_o  (pwdata),
    .apb_pwrite_o  (pwrite),
    .apb_psel_o    (psel),
    .apb_penable_o (penable),
    .apb_prdata_i  (32'h0),
    .apb_pready_i  (pready),
    .apb_pslverr_i (pslverr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_wr(input logic [11:0] a, input logic [31:0] d);
    wr_q.push_back('{addr: a, data: d});
  endtask

  // Responder and APB write monitor: decide pready for the coming edge, then score it.
  always @(negedge clk) begin
    if (rst) begin
      pready = 1'b0; pslverr = 1'b0; wcnt = 0;
    end else if (psel && penable) begin
      chk("access_addr_stable", 32'(paddr), 32'(setup_addr));
      chk("access_data_stable", pwdata, setup_data);
      if (!hang && wcnt >= wait_cfg[paddr[3:2]]) begin
        pready = 1'b1; pslverr = err_cfg[paddr[3:2]];
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL apb_unexpected_write: got addr %0h data %0h required none", paddr, pwdata);
        end else begin
          we = wr_q.pop_front();
          chk("apb_addr", 32'(paddr), 32'(we.addr));
          chk("apb_data", pwdata, we.data);
          chk("apb_pwrite", 32'(pwrite), 32'd1);
        end
      end else begin
        pready = 1'b0; pslverr = 1'b0; wcnt++;
      end
    end else begin
      pready = 1'b0; pslverr = 1'b0; wcnt = 0;
      if (psel) begin setup_addr = paddr; setup_data = pwdata; end
    end
  end

  always @(negedge clk) begin
    if (!rst && done) begin
      done_seen++;
      $display("done: err=%0b latency=%0d", err, cyc - acc_cyc);
      chk("done_psel_low", 32'(psel), 32'd0);
      chk("done_ready_low", 32'(req_ready), 32'd0);
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done err=%0b required no done", err);
      end else begin
        de = done_q.pop_front();
        chk("done_err", 32'(err), 32'(de.err));
        chk("done_latency", 32'(cyc - acc_cyc), 32'(de.lat));
      end
    end
  end

  task automatic issue(input logic [10:0] x, input logic [10:0] y, input logic c);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_x = x; req_y = y; req_c = c;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout: got ready 0 required 1");
    end
    acc_cyc = cyc;
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic send(input logic [10:0] x, input logic [10:0] y, input logic c,
                      input int lat, input logic e);
    int n, prev;
    done_q.push_back('{lat: lat, err: e});
    prev = done_seen;
    issue(x, y, c);
    n = 0;
    while (done_seen == prev && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (done_seen == prev) begin
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles required done", n);
    end
    @(negedge clk);
  endtask

  initial begin
    foreach (wait_cfg[i]) begin wait_cfg[i] = 0; err_cfg[i] = 1'b0; end
    repeat (3) @(negedge clk);
    chk("reset_psel", 32'(psel), 32'd0);
    chk("reset_penable", 32'(penable), 32'd0);
    chk("reset_pwrite", 32'(pwrite), 32'd0);
    chk("reset_paddr", 32'(paddr), 32'd0);
    chk("reset_pwdata", pwdata, 32'd0);
    chk("reset_done_err", {30'd0, done, err}, 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    exp_wr(12'h0, 100); exp_wr(12'h4, 50); exp_wr(12'h8, 1); exp_wr(12'hC, 1);
    send(11'd100, 11'd50, 1'b1, 9, 1'b0);

    exp_wr(12'h4, 51); exp_wr(12'hC, 1);
    send(11'd100, 11'd51, 1'b1, 5, 1'b0);

    wait_cfg[1] = 3;
    exp_wr(12'h0, 101); exp_wr(12'h4, 52); exp_wr(12'h8, 0); exp_wr(12'hC, 1);
    send(11'd101, 11'd52, 1'b0, 12, 1'b0);
    wait_cfg[1] = 0;

    err_cfg[2] = 1'b1;
    exp_wr(12'h8, 1);
    send(11'd101, 11'd52, 1'b1, 3, 1'b1);
    err_cfg[2] = 1'b0;
    exp_wr(12'h0, 101); exp_wr(12'h4, 52); exp_wr(12'h8, 1); exp_wr(12'hC, 1);
    send(11'd101, 11'd52, 1'b1, 9, 1'b0);

    hang = 1'b1;
    send(11'd200, 11'd52, 1'b1, 18, 1'b1);

    // Reset while the X write is waiting in ACCESS.
    issue(11'd300, 11'd60, 1'b0);
    for (int n = 0; n < 10 && !(psel && penable); n++) @(negedge clk);
    chk("pre_reset_access", {30'd0, psel, penable}, 32'd3);
    chk("pre_reset_addr", 32'(paddr), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_psel", 32'(psel), 32'd0);
    chk("mid_reset_penable", 32'(penable), 32'd0);
    chk("mid_reset_ready", 32'(req_ready), 32'd1);
    chk("mid_reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    hang = 1'b0;
    repeat (5) @(negedge clk);

    exp_wr(12'h0, 100); exp_wr(12'h4, 50); exp_wr(12'h8, 1); exp_wr(12'hC, 1);
    send(11'd100, 11'd50, 1'b1, 9, 1'b0);
    exp_wr(12'h8, 0); exp_wr(12'hC, 1);
    send(11'd100, 11'd50, 1'b0, 5, 1'b0);
    exp_wr(12'hC, 1);
    send(11'd100, 11'd50, 1'b0, 3, 1'b0);

    repeat (3) @(negedge clk);
    chk("leftover_writes", 32'(wr_q.size()), 32'd0);
    chk("leftover_dones", 32'(done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
